mips_exec_core: RTL and testbench
=================================

// Module: mips_exec_core
// PURPOSE
// Execution datapath core of the multicycle MIPS32 CPU: 32x32 register file, combinational ALU/branch
// evaluator, and HI/LO unit with single-cycle multiply and iterative divide. The FSM controller drives
// the decoded fields and indices and sequences write-back; this block holds all architectural data state.
// PARAMETERS
// REG_RESET_VALUE  32'h0  value loaded into every GPR (except $0) and into HI/LO on reset
// PORTS
// clk            in   1   system clock, all state updates on posedge
// reset          in   1   synchronous, active-high
// opcode         in   6   instr[31:26]
// funct          in   6   instr[5:0]
// shamt          in   5   instr[10:6]
// imm            in   16  instr[15:0]
// rs_index       in   5   read port A index
// rt_index       in   5   read port B index; also the REGIMM selector
// write_index    in   5   write port index
// write_enable   in   1   GPR write strobe
// write_data     in   32  GPR write value
// div_valid_in   in   1   one-cycle divide start pulse
// read_data_rs   out  32  GPR[rs_index]
// read_data_rt   out  32  GPR[rt_index]
// register_v0    out  32  GPR[2], continuous
// alu_out        out  32  ALU result
// zero_flag      out  1   alu_out == 0
// carry_out      out  1   bit 32 of the unsigned sum for ADDU/ADDIU, else 0
// branch_cond    out  1   branch condition true
// link           out  1   REGIMM link variant (BLTZAL/BGEZAL)
// overflow       out  1   signed overflow (see CONFIGURATION)
// div_valid_out  out  1   one-cycle divide-done pulse
// hi_out, lo_out out  32  HI/LO registers, continuous
// BEHAVIOUR
// - Reset: all GPRs, HI and LO = REG_RESET_VALUE; divider idle; div_valid_out=0. Reset mid-divide aborts it.
// - GPR: combinational reads; $0 always reads 0 and ignores writes. Write on posedge when write_enable.
//   Same-cycle read of the index being written returns the old value (no bypass).
// - ALU, opcode 0, by funct: SLL/SRL/SRA rt by shamt; SLLV/SRLV/SRAV rt by rs[4:0]; ADDU, SUBU, AND, OR,
//   XOR, NOR; SLT signed; SLTU unsigned (result 0/1). Any other funct gives alu_out=0.
// - Immediate ops: ADDIU rs+sext(imm); SLTI signed and SLTIU unsigned compare against sext(imm);
//   ANDI/ORI/XORI use zext(imm); LUI gives {imm,16'h0}.
// - Loads and stores (opcodes 0x20-0x2B) give alu_out = rs + sext(imm), modulo 2^32.
// - Branch conditions:
//   BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0 (signed).
//   REGIMM (opcode 1) by rt_index: 0 BLTZ, 1 BGEZ, 16 BLTZAL, 17 BGEZAL.
//   link=1 for 16/17 regardless of condition. branch_cond=0 for all non-branch opcodes.
// - HI/LO (opcode 0 only): acts on every posedge where funct is presented; controller holds operands stable.
//   MULT/MULTU: {HI,LO} <= 64-bit signed/unsigned rs*rt, same edge.
//   MTHI: HI<=rs. MTLO: LO<=rs. MFHI/MFLO are read via hi_out/lo_out.
// - Divide (funct DIV/DIVU):
//   - Start on a posedge with div_valid_in=1 while idle; rs/rt latched at start.
//   - 32 radix-2 iterations: on the 32nd edge after start, LO<=quotient, HI<=remainder and
//     div_valid_out=1 for exactly one cycle.
//   - Signed: quotient truncates toward zero; remainder takes the sign of rs.
//   - Divide by zero: LO=32'hFFFFFFFF, HI=rs, same latency.
//   - While busy: div_valid_in and all HI/LO writes are ignored.
// - Arithmetic wraps modulo 2^32; no exceptions raised.
// CONFIGURATION
// - MIPS_EXEC_OVERFLOW_EN defined: ADD (funct 0x20), SUB (0x22) and ADDI (opcode 0x08) are computed;
//   overflow=1 on signed overflow of these.
// - Not defined: those codes give alu_out=0 and overflow is tied to 0.
// TESTING
// - Reset, then write $2=32'h12345678 and $0=5 -> register_v0=32'h12345678; read of $0 returns 0.
// - ADDU 32'hFFFFFFFF+1 -> alu_out=0, zero_flag=1, carry_out=1; SRA 32'h80000000 by 4 -> 32'hF8000000.
// - SLTI with rs=-1, imm=0 -> 1; SLTIU with rs=1, imm=16'hFFFF -> 1; LUI imm=16'hABCD -> 32'hABCD0000.
// - REGIMM rt_index=17, rs=0 -> branch_cond=1, link=1; BGTZ rs=0 -> branch_cond=0.
// - MULT rs=-2, rt=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; MULTU 32'hFFFFFFFF^2 -> HI=32'hFFFFFFFE, LO=1.
// - DIV rs=-7, rt=2 with pulse -> 32 edges later div_valid_out=1, LO=-3, HI=-1; DIVU by 0 -> LO=32'hFFFFFFFF.

Source files
------------

// File: rtl/mips_exec_core.sv
// rtl/mips_exec_core.sv - MIPS32 execution datapath: GPR file, ALU/branch evaluator, HI/LO multiply/divide
//
// Purpose: holds all architectural data state of the multicycle CPU. The external controller
// presents decoded instruction fields and register indices and sequences write-back; this block
// returns register reads, the combinational ALU/branch results and the HI/LO registers.
//
// Optional feature macro: MIPS_EXEC_OVERFLOW_EN
//   defined     : ADD/SUB/ADDI are computed and flag signed overflow on 'overflow'
//   not defined : those codes produce alu_out = 0 and 'overflow' is tied low
//
// Parameters:
//   REG_RESET_VALUE  value loaded into GPR $1..$31, HI and LO on reset
//
// Ports:
//   clk, reset                      clock; synchronous active-high reset
//   opcode, funct, shamt, imm       decoded instruction fields
//   rs_index, rt_index              read port indices (rt_index also selects the REGIMM variant)
//   write_index/enable/data         GPR write port
//   div_valid_in / div_valid_out    divide start pulse / divide done pulse
//   read_data_rs, read_data_rt      combinational GPR reads ($0 reads as 0)
//   register_v0                     GPR[2]
//   alu_out, zero_flag, carry_out   ALU result and flags
//   branch_cond, link, overflow     branch evaluation, REGIMM link variant, signed overflow
//   hi_out, lo_out                  HI/LO registers

module mips_exec_core #(
    parameter logic [31:0] REG_RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [4:0]  rs_index,
    input  logic [4:0]  rt_index,
    input  logic [4:0]  write_index,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic        div_valid_in,
    output logic [31:0] read_data_rs,
    output logic [31:0] read_data_rt,
    output logic [31:0] register_v0,
    output logic [31:0] alu_out,
    output logic        zero_flag,
    output logic        carry_out,
    output logic        branch_cond,
    output logic        link,
    output logic        overflow,
    output logic        div_valid_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_MEM_LO  = 6'h20;
    localparam logic [5:0] OP_MEM_HI  = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
`ifdef MIPS_EXEC_OVERFLOW_EN
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
`endif

    typedef enum logic {
        S_DIV_IDLE,
        S_DIV_BUSY
    } div_state_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] r_gpr [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= REG_RESET_VALUE;
            end
        end else if (write_enable && (write_index != 5'd0)) begin
            r_gpr[write_index] <= write_data;
        end
    end

    // $0 is decoded on the read side, so its storage entry is never observed.
    assign read_data_rs = (rs_index == 5'd0) ? 32'h0 : r_gpr[rs_index];
    assign read_data_rt = (rt_index == 5'd0) ? 32'h0 : r_gpr[rt_index];
    assign register_v0  = r_gpr[2];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [32:0] w_sum_rr;
    logic [32:0] w_sum_ri;
    logic [31:0] w_diff;
    logic        w_slt;
    logic        w_slti;
    logic [31:0] w_alu;
    logic        w_carry;
`ifdef MIPS_EXEC_OVERFLOW_EN
    logic        w_ovf;
`endif

    assign w_a      = read_data_rs;
    assign w_b      = read_data_rt;
    assign w_simm   = {{16{imm[15]}}, imm};
    assign w_zimm   = {16'h0, imm};
    assign w_sum_rr = {1'b0, w_a} + {1'b0, w_b};
    assign w_sum_ri = {1'b0, w_a} + {1'b0, w_simm};
    assign w_diff   = w_a - w_b;
    assign w_slt    = $signed(w_a) < $signed(w_b);
    assign w_slti   = $signed(w_a) < $signed(w_simm);

    always_comb begin
        w_alu   = 32'h0;
        w_carry = 1'b0;
`ifdef MIPS_EXEC_OVERFLOW_EN
        w_ovf   = 1'b0;
`endif
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_SLL:   w_alu = w_b << shamt;
                    F_SRL:   w_alu = w_b >> shamt;
                    F_SRA:   w_alu = $signed(w_b) >>> shamt;
                    F_SLLV:  w_alu = w_b << w_a[4:0];
                    F_SRLV:  w_alu = w_b >> w_a[4:0];
                    F_SRAV:  w_alu = $signed(w_b) >>> w_a[4:0];
                    F_ADDU: begin
                        w_alu   = w_sum_rr[31:0];
                        w_carry = w_sum_rr[32];
                    end
                    F_SUBU:  w_alu = w_diff;
                    F_AND:   w_alu = w_a & w_b;
                    F_OR:    w_alu = w_a | w_b;
                    F_XOR:   w_alu = w_a ^ w_b;
                    F_NOR:   w_alu = ~(w_a | w_b);
                    F_SLT:   w_alu = {31'h0, w_slt};
                    F_SLTU:  w_alu = {31'h0, (w_a < w_b)};
`ifdef MIPS_EXEC_OVERFLOW_EN
                    // Overflow: operands agree in sign but the result does not.
                    F_ADD: begin
                        w_alu = w_sum_rr[31:0];
                        w_ovf = (w_a[31] == w_b[31]) && (w_sum_rr[31] != w_a[31]);
                    end
                    F_SUB: begin
                        w_alu = w_diff;
                        w_ovf = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
                    end
`endif
                    default: w_alu = 32'h0;
                endcase
            end
`ifdef MIPS_EXEC_OVERFLOW_EN
            OP_ADDI: begin
                w_alu = w_sum_ri[31:0];
                w_ovf = (w_a[31] == w_simm[31]) && (w_sum_ri[31] != w_a[31]);
            end
`endif
            OP_ADDIU: begin
                w_alu   = w_sum_ri[31:0];
                w_carry = w_sum_ri[32];
            end
            OP_SLTI:  w_alu = {31'h0, w_slti};
            OP_SLTIU: w_alu = {31'h0, (w_a < w_simm)};
            OP_ANDI:  w_alu = w_a & w_zimm;
            OP_ORI:   w_alu = w_a | w_zimm;
            OP_XORI:  w_alu = w_a ^ w_zimm;
            OP_LUI:   w_alu = {imm, 16'h0};
            default: begin
                // Loads and stores use the ALU for effective-address generation.
                if ((opcode >= OP_MEM_LO) && (opcode <= OP_MEM_HI)) begin
                    w_alu = w_sum_ri[31:0];
                end
            end
        endcase
    end

    assign alu_out   = w_alu;
    assign zero_flag = (w_alu == 32'h0);
    assign carry_out = w_carry;
`ifdef MIPS_EXEC_OVERFLOW_EN
    assign overflow  = w_ovf;
`else
    assign overflow  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Branch evaluation
    // ------------------------------------------------------------------
    logic w_rs_neg;
    logic w_rs_zero;
    logic w_branch;
    logic w_link;

    assign w_rs_neg  = w_a[31];
    assign w_rs_zero = (w_a == 32'h0);

    always_comb begin
        w_branch = 1'b0;
        w_link   = 1'b0;
        case (opcode)
            OP_REGIMM: begin
                case (rt_index)
                    5'd0:  w_branch = w_rs_neg;
                    5'd1:  w_branch = ~w_rs_neg;
                    5'd16: begin
                        w_branch = w_rs_neg;
                        w_link   = 1'b1;
                    end
                    5'd17: begin
                        w_branch = ~w_rs_neg;
                        w_link   = 1'b1;
                    end
                    default: w_branch = 1'b0;
                endcase
            end
            OP_BEQ:  w_branch = (w_a == w_b);
            OP_BNE:  w_branch = (w_a != w_b);
            OP_BLEZ: w_branch = w_rs_neg | w_rs_zero;
            OP_BGTZ: w_branch = ~w_rs_neg & ~w_rs_zero;
            default: w_branch = 1'b0;
        endcase
    end

    assign branch_cond = w_branch;
    assign link        = w_link;

    // ------------------------------------------------------------------
    // HI/LO unit: single-cycle multiply, 32-step restoring divide
    // ------------------------------------------------------------------
    logic [63:0] w_mul_s;
    logic [63:0] w_mul_u;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_mul_s = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
    assign w_mul_u = {32'h0, w_a} * {32'h0, w_b};

    div_state_t  r_div_state;
    div_state_t  w_div_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [31:0] r_dvd_raw;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_dvz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div_done;

    logic        w_div_start;
    logic        w_div_last;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;

    assign w_div_start  = (r_div_state == S_DIV_IDLE) && div_valid_in &&
                          (opcode == OP_SPECIAL) && ((funct == F_DIV) || (funct == F_DIVU));
    assign w_div_last   = (r_div_state == S_DIV_BUSY) && (r_count == 5'd31);
    assign w_div_signed = (funct == F_DIV);
    assign w_a_neg      = w_div_signed & w_a[31];
    assign w_b_neg      = w_div_signed & w_b[31];

    // Partial remainder stays below the divisor, so bit 32 of the trial
    // subtraction is exactly the borrow (trial failed).
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
    assign w_quo_next = {r_quo[30:0], ~w_trial[32]};
    assign w_q_final  = r_q_neg ? (32'h0 - w_quo_next) : w_quo_next;
    assign w_r_final  = r_r_neg ? (32'h0 - w_rem_next) : w_rem_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_state <= S_DIV_IDLE;
        end else begin
            r_div_state <= w_div_state_next;
        end
    end

    always_comb begin
        w_div_state_next = r_div_state;
        case (r_div_state)
            S_DIV_IDLE: if (w_div_start) w_div_state_next = S_DIV_BUSY;
            S_DIV_BUSY: if (w_div_last)  w_div_state_next = S_DIV_IDLE;
            default:    w_div_state_next = S_DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= REG_RESET_VALUE;
            r_lo       <= REG_RESET_VALUE;
            r_div_done <= 1'b0;
            r_count    <= 5'd0;
            r_rem      <= 32'h0;
            r_quo      <= 32'h0;
            r_dvs      <= 32'h0;
            r_dvd_raw  <= 32'h0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dvz      <= 1'b0;
        end else begin
            r_div_done <= 1'b0;
            if (r_div_state == S_DIV_BUSY) begin
                // Busy: one iteration per edge; all HI/LO requests are dropped.
                r_rem   <= w_rem_next;
                r_quo   <= w_quo_next;
                r_count <= r_count + 5'd1;
                if (w_div_last) begin
                    r_div_done <= 1'b1;
                    if (r_dvz) begin
                        r_lo <= 32'hFFFF_FFFF;
                        r_hi <= r_dvd_raw;
                    end else begin
                        r_lo <= w_q_final;
                        r_hi <= w_r_final;
                    end
                end
            end else if (opcode == OP_SPECIAL) begin
                case (funct)
                    F_MULT:  {r_hi, r_lo} <= w_mul_s;
                    F_MULTU: {r_hi, r_lo} <= w_mul_u;
                    F_MTHI:  r_hi <= w_a;
                    F_MTLO:  r_lo <= w_a;
                    default: begin
                        if (w_div_start) begin
                            r_count   <= 5'd0;
                            r_rem     <= 32'h0;
                            r_quo     <= w_a_neg ? (32'h0 - w_a) : w_a;
                            r_dvs     <= w_b_neg ? (32'h0 - w_b) : w_b;
                            r_dvd_raw <= w_a;
                            r_q_neg   <= w_a_neg ^ w_b_neg;
                            r_r_neg   <= w_a_neg;
                            r_dvz     <= (w_b == 32'h0);
                        end
                    end
                endcase
            end
        end
    end

    assign hi_out        = r_hi;
    assign lo_out        = r_lo;
    assign div_valid_out = r_div_done;

endmodule

// File: tb/tb_mips_exec_core.sv
// tb/tb_mips_exec_core.sv - randomized self-checking bench for mips_exec_core against an arithmetic model

module tb_mips_exec_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [4:0]  rs_index;
    logic [4:0]  rt_index;
    logic [4:0]  write_index;
    logic        write_enable;
    logic [31:0] write_data;
    logic        div_valid_in;
    logic [31:0] read_data_rs;
    logic [31:0] read_data_rt;
    logic [31:0] register_v0;
    logic [31:0] alu_out;
    logic        zero_flag;
    logic        carry_out;
    logic        branch_cond;
    logic        link;
    logic        overflow;
    logic        div_valid_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    mips_exec_core dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .shamt(shamt), .imm(imm),
        .rs_index(rs_index), .rt_index(rt_index), .write_index(write_index),
        .write_enable(write_enable), .write_data(write_data), .div_valid_in(div_valid_in),
        .read_data_rs(read_data_rs), .read_data_rt(read_data_rt), .register_v0(register_v0),
        .alu_out(alu_out), .zero_flag(zero_flag), .carry_out(carry_out),
        .branch_cond(branch_cond), .link(link), .overflow(overflow),
        .div_valid_out(div_valid_out), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    // (opcode, funct) pairs exercised by the random ALU/branch phase
    localparam logic [11:0] TAB [32] = '{
        {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03}, {6'h00, 6'h04},
        {6'h00, 6'h06}, {6'h00, 6'h07}, {6'h00, 6'h20}, {6'h00, 6'h21},
        {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25},
        {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B},
        {6'h00, 6'h05}, {6'h01, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
        {6'h06, 6'h00}, {6'h07, 6'h00}, {6'h08, 6'h00}, {6'h09, 6'h00},
        {6'h0A, 6'h00}, {6'h0B, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00},
        {6'h0E, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Behavioural reference: instruction semantics in plain integer arithmetic.
    task automatic ref_exec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [15:0] im, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rti, output logic [31:0] r, output logic c,
                            output logic v, output logic br, output logic lk);
        logic [31:0] se;
        longint      t;
        longint unsigned u;
        se = {{16{im[15]}}, im};
        r = 0; c = 0; v = 0; br = 0; lk = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = int'(b) >>> sh;
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: r = int'(b) >>> a[4:0];
                6'h21: begin u = longint'(a) + longint'(b); r = u[31:0]; c = (u >= 64'h1_0000_0000); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = (int'(a) < int'(b)) ? 1 : 0;
                6'h2B: r = (a < b) ? 1 : 0;
`ifdef MIPS_EXEC_OVERFLOW_EN
                6'h20: begin t = longint'(int'(a)) + longint'(int'(b)); r = a + b;
                             v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
                6'h22: begin t = longint'(int'(a)) - longint'(int'(b)); r = a - b;
                             v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
`endif
                default: r = 0;
            endcase
        end else if (op == 6'h01) begin
            lk = (rti == 5'd16) || (rti == 5'd17);
            if (rti == 5'd0 || rti == 5'd16) br = int'(a) < 0;
            if (rti == 5'd1 || rti == 5'd17) br = int'(a) >= 0;
        end else if (op == 6'h04) br = (a == b);
        else if (op == 6'h05) br = (a != b);
        else if (op == 6'h06) br = int'(a) <= 0;
        else if (op == 6'h07) br = int'(a) > 0;
`ifdef MIPS_EXEC_OVERFLOW_EN
        else if (op == 6'h08) begin
            t = longint'(int'(a)) + longint'(int'(se)); r = a + se;
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        end
`endif
        else if (op == 6'h09) begin u = longint'(a) + longint'(se); r = u[31:0]; c = (u >= 64'h1_0000_0000); end
        else if (op == 6'h0A) r = (int'(a) < int'(se)) ? 1 : 0;
        else if (op == 6'h0B) r = (a < se) ? 1 : 0;
        else if (op == 6'h0C) r = a & {16'h0, im};
        else if (op == 6'h0D) r = a | {16'h0, im};
        else if (op == 6'h0E) r = a ^ {16'h0, im};
        else if (op == 6'h0F) r = {im, 16'h0};
        else if (op >= 6'h20 && op <= 6'h2B) r = a + se;
    endtask

    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
        else if (!sgn) begin q = a / b; r = a % b; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 0; end
        else begin q = sa / sb; r = sa % sb; end
    endtask

    task automatic idle_fields();
        opcode = 6'h02; funct = 6'h00; shamt = 0; imm = 0; div_valid_in = 0;
    endtask

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        write_index = idx; write_data = val; write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
        if (idx != 0) m_gpr[idx] = val;
    endtask

    task automatic alu_check(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [15:0] im,
                             input logic [4:0] rsi, input logic [4:0] rti);
        logic [31:0] r;
        logic c, v, br, lk;
        @(negedge clk);
        opcode = op; funct = fn; shamt = sh; imm = im; rs_index = rsi; rt_index = rti;
        #1;
        ref_exec(op, fn, sh, im, m_gpr[rsi], m_gpr[rti], rti, r, c, v, br, lk);
        check({tag, "_alu"}, {32'h0, alu_out}, {32'h0, r});
        check({tag, "_flags"}, {59'h0, zero_flag, carry_out, branch_cond, link, overflow},
              {59'h0, (r == 0), c, br, lk, v});
    endtask

    task automatic hilo_op(input string tag, input logic [5:0] fn, input logic [4:0] rsi,
                           input logic [4:0] rti);
        logic [31:0] a, b;
        longint      ps;
        longint unsigned pu;
        a = m_gpr[rsi];
        b = m_gpr[rti];
        @(negedge clk);
        opcode = 6'h00; funct = fn; rs_index = rsi; rt_index = rti;
        @(posedge clk);
        #1 idle_fields();
        if (fn == 6'h18) begin ps = longint'(int'(a)) * longint'(int'(b)); {m_hi, m_lo} = ps; end
        if (fn == 6'h19) begin pu = longint'(a) * longint'(b); {m_hi, m_lo} = pu; end
        if (fn == 6'h11) m_hi = a;
        if (fn == 6'h13) m_lo = a;
        check({tag, "_hi"}, {32'h0, hi_out}, {32'h0, m_hi});
        check({tag, "_lo"}, {32'h0, lo_out}, {32'h0, m_lo});
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [4:0] rsi,
                          input logic [4:0] rti, input logic interfere);
        logic [31:0] q, r;
        int got;
        ref_div(sgn, m_gpr[rsi], m_gpr[rti], q, r);
        @(negedge clk);
        opcode = 6'h00; funct = sgn ? 6'h1A : 6'h1B; rs_index = rsi; rt_index = rti;
        div_valid_in = 1'b1;
        @(posedge clk);
        #1 idle_fields();
        got = 0;
        for (int n = 1; n <= 40; n++) begin
            if (interfere && n == 5) begin
                opcode = 6'h00; funct = 6'h11; rs_index = 5'd13;
            end
            if (interfere && n == 9) begin
                opcode = 6'h00; funct = 6'h1B; rs_index = 5'd14; rt_index = 5'd15;
                div_valid_in = 1'b1;
            end
            @(posedge clk);
            #1;
            if (interfere && n == 5) check({tag, "_busy_mthi"}, {32'h0, hi_out}, {32'h0, m_hi});
            idle_fields();
            if (div_valid_out) begin
                got = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(got), 64'd32);
        m_lo = q;
        m_hi = r;
        check({tag, "_lo"}, {32'h0, lo_out}, {32'h0, m_lo});
        check({tag, "_hi"}, {32'h0, hi_out}, {32'h0, m_hi});
        @(posedge clk);
        #1 check({tag, "_pulse_once"}, {63'h0, div_valid_out}, 64'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ri, rj;
        logic [11:0] e;
        int pulses;

        reset = 1'b1; write_enable = 1'b0; write_index = 0; write_data = 0;
        rs_index = 0; rt_index = 0;
        idle_fields();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 0; m_lo = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_v0", {32'h0, register_v0}, 64'h0);
        check("rst_hilo", {hi_out, lo_out}, 64'h0);
        check("rst_divv", {63'h0, div_valid_out}, 64'h0);
        rs_index = 5'd17; rt_index = 5'd31;
        #1 check("rst_reads", {read_data_rs, read_data_rt}, 64'h0);

        // Register file basics
        set_reg(5'd2, 32'h1234_5678);
        set_reg(5'd0, 32'h5);
        check("v0_write", {32'h0, register_v0}, {32'h0, 32'h1234_5678});
        rs_index = 5'd0; rt_index = 5'd2;
        #1 check("r0_read", {read_data_rs, read_data_rt}, {32'h0, 32'h1234_5678});

        // No bypass on same-cycle read of the register being written
        @(negedge clk);
        write_index = 5'd7; write_data = 32'hCAFE_F00D; write_enable = 1'b1; rs_index = 5'd7;
        #1 check("no_bypass_old", {32'h0, read_data_rs}, {32'h0, m_gpr[7]});
        @(posedge clk);
        #1 write_enable = 1'b0;
        m_gpr[7] = 32'hCAFE_F00D;
        check("no_bypass_new", {32'h0, read_data_rs}, {32'h0, 32'hCAFE_F00D});

        // Directed ALU and branch cases
        set_reg(5'd3, 32'hFFFF_FFFF);
        set_reg(5'd4, 32'h1);
        set_reg(5'd5, 32'h8000_0000);
        alu_check("addu_wrap", 6'h00, 6'h21, 0, 0, 5'd3, 5'd4);
        check("addu_wrap_const", {alu_out, 29'h0, zero_flag, carry_out, 1'b0}, {32'h0, 29'h0, 3'b110});
        alu_check("sra", 6'h00, 6'h03, 5'd4, 0, 5'd0, 5'd5);
        check("sra_const", {32'h0, alu_out}, {32'h0, 32'hF800_0000});
        alu_check("slti", 6'h0A, 6'h00, 0, 16'h0000, 5'd3, 5'd0);
        check("slti_const", {32'h0, alu_out}, 64'h1);
        alu_check("sltiu", 6'h0B, 6'h00, 0, 16'hFFFF, 5'd4, 5'd0);
        check("sltiu_const", {32'h0, alu_out}, 64'h1);
        alu_check("lui", 6'h0F, 6'h00, 0, 16'hABCD, 5'd3, 5'd0);
        check("lui_const", {32'h0, alu_out}, {32'h0, 32'hABCD_0000});
        alu_check("bgezal", 6'h01, 6'h00, 0, 0, 5'd0, 5'd17);
        check("bgezal_const", {62'h0, branch_cond, link}, 64'h3);
        alu_check("bgtz0", 6'h07, 6'h00, 0, 0, 5'd0, 5'd0);
        check("bgtz0_const", {63'h0, branch_cond}, 64'h0);
        alu_check("sw_addr", 6'h2B, 6'h00, 0, 16'hFFFC, 5'd4, 5'd0);

        // Directed multiply
        set_reg(5'd6, 32'hFFFF_FFFE);
        set_reg(5'd8, 32'h3);
        hilo_op("mult", 6'h18, 5'd6, 5'd8);
        check("mult_const", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        hilo_op("multu", 6'h19, 5'd3, 5'd3);
        check("multu_const", {hi_out, lo_out}, {32'hFFFF_FFFE, 32'h1});

        // Directed divide
        set_reg(5'd9, 32'hFFFF_FFF9);
        set_reg(5'd10, 32'h2);
        do_div("div_m7_2", 1'b1, 5'd9, 5'd10, 1'b0);
        check("div_const", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("divu_by0", 1'b0, 5'd9, 5'd0, 1'b0);
        check("divu0_const", {hi_out, lo_out}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        // Randomized register contents
        for (int i = 1; i < 32; i++) set_reg(5'(i), rand_val());

        // Randomized ALU / branch operations
        for (int k = 0; k < 80; k++) begin
            e = TAB[$urandom_range(0, 31)];
            alu_check("rnd_alu", e[11:6], (e[11:6] == 6'h00) ? e[5:0] : 6'($urandom_range(0, 63)),
                      5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Randomized HI/LO operations
        for (int k = 0; k < 16; k++) begin
            ri = 5'($urandom_range(0, 31));
            rj = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: hilo_op("rnd_mult", 6'h18, ri, rj);
                1: hilo_op("rnd_multu", 6'h19, ri, rj);
                2: hilo_op("rnd_mthi", 6'h11, ri, rj);
                default: hilo_op("rnd_mtlo", 6'h13, ri, rj);
            endcase
        end

        // Randomized divides, some with requests arriving while busy
        set_reg(5'd13, ~m_hi);
        for (int k = 0; k < 8; k++) begin
            ri = 5'($urandom_range(1, 31));
            rj = (k == 3) ? 5'd0 : 5'($urandom_range(1, 31));
            do_div("rnd_div", 1'($urandom_range(0, 1)), ri, rj, (k % 2) == 1);
        end

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        opcode = 6'h00; funct = 6'h1A; rs_index = 5'd9; rt_index = 5'd10; div_valid_in = 1'b1;
        @(posedge clk);
        #1 idle_fields();
        repeat (10) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1 if (div_valid_out) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'h0);
        check("abort_hilo", {hi_out, lo_out}, 64'h0);
        check("abort_v0", {32'h0, register_v0}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
